// File: rtl/sync_mem_mp_fwd_pkg.sv
// Shared types and helpers for the multi-read-port synchronous memory.
// be_merge works on a fixed maximum width; callers size-cast in and out.
package sync_mem_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_DATA_W = 512;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / BYTE_W;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } mem_state_e;

  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_mem_mp_fwd_rd_port.sv
// One read port: write-address compare, byte-merge forwarding, output registers.
// SYNC_MEM_OUT_REG_EN adds a second output stage (latency 2).
module sync_mem_rd_port
  import sync_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rd_accept,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_word,
  input  logic                         wr_accept,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH/BYTE_W-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid
);

  logic                  hit;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  always_comb begin
    hit  = wr_accept && (rd_addr == wr_addr);
    word = mem_word;
    if (hit) begin
      word = DATA_WIDTH'(be_merge(MAX_DATA_W'(mem_word), MAX_DATA_W'(wr_data),
                                  MAX_BE_W'(wr_be)));
    end
    valid_d = rd_accept;
    data_d  = rd_accept ? word : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef SYNC_MEM_OUT_REG_EN
  // Forwarding was resolved in the address cycle; this stage only delays it.
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  always_comb begin
    out_valid_d = valid_q;
    out_data_d  = valid_q ? data_q : out_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;
`else
  assign rd_data  = data_q;
  assign rd_valid = valid_q;
`endif

endmodule

// File: rtl/sync_mem_mp_fwd.sv
// Flop-based memory: one byte-enabled write port, NUM_RD forwarding read ports, self-clear FSM.
// Optional macro SYNC_MEM_OUT_REG_EN: extra read output register stage (latency 2).
module sync_mem_mp_fwd
  import sync_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clr,
  output logic                                ready,
  input  logic                                wr_en,
  input  logic [ADDR_WIDTH-1:0]               wr_addr_in,
  input  logic [DATA_WIDTH/8-1:0]             wr_be_in,
  input  logic [DATA_WIDTH-1:0]               wr_data_in,
  input  logic [NUM_RD-1:0]                   rd_en,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   rd_addr_in,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rd_data_out,
  output logic [NUM_RD-1:0]                   rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH > MAX_DATA_W) begin : g_bad_width
    $error("sync_mem_mp_fwd: DATA_WIDTH must be a multiple of 8 and <= MAX_DATA_W");
  end
  if (NUM_RD < 1) begin : g_bad_num_rd
    $error("sync_mem_mp_fwd: NUM_RD must be >= 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  mem_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  wr_accept;
  logic                  rd_ok;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] wr_merged;

  assign wr_merged = DATA_WIDTH'(be_merge(MAX_DATA_W'(mem_q[wr_addr_in]),
                                          MAX_DATA_W'(wr_data_in),
                                          MAX_BE_W'(wr_be_in)));

  // The clear FSM owns the single array write port while in ST_INIT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_accept = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr_in;
    mem_wdata = wr_merged;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (wr_en) begin
          wr_accept = 1'b1;
          mem_we    = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
    ready_d = (state_d == ST_READY);
  end

  assign rd_ok = (state_q == ST_READY);
  assign ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    sync_mem_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_accept (rd_ok & rd_en[p]),
      .rd_addr   (rd_addr_in[p]),
      .mem_word  (mem_q[rd_addr_in[p]]),
      .wr_accept (wr_accept),
      .wr_addr   (wr_addr_in),
      .wr_be     (wr_be_in),
      .wr_data   (wr_data_in),
      .rd_data   (rd_data_out[p]),
      .rd_valid  (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_sync_mem_mp_fwd.sv
// Self-checking bench for sync_mem_mp_fwd: vector table plus read scoreboard.
module tb_sync_mem_mp_fwd;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 2;
`ifdef SYNC_MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    clr;
  logic                    ready;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr_in;
  logic [DW/8-1:0]         wr_be_in;
  logic [DW-1:0]           wr_data_in;
  logic [NR-1:0]           rd_en;
  logic [NR-1:0][AW-1:0]   rd_addr_in;
  logic [NR-1:0][DW-1:0]   rd_data_out;
  logic [NR-1:0]           rd_valid;

  always #5 clk = ~clk;

  sync_mem_mp_fwd #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .ready       (ready),
    .wr_en       (wr_en),
    .wr_addr_in  (wr_addr_in),
    .wr_be_in    (wr_be_in),
    .wr_data_in  (wr_data_in),
    .rd_en       (rd_en),
    .rd_addr_in  (rd_addr_in),
    .rd_data_out (rd_data_out),
    .rd_valid    (rd_valid)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [7:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [7:0]  ra0;
    logic [7:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  logic [31:0] last_data [NR];
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle();
    clr        = 1'b0;
    wr_en      = 1'b0;
    wr_addr_in = '0;
    wr_be_in   = '0;
    wr_data_in = '0;
    rd_en      = '0;
    rd_addr_in = '0;
  endtask

  task automatic push_read(input int p, input logic [7:0] addr, input logic [31:0] exp);
    rd_en[p]      = 1'b1;
    rd_addr_in[p] = addr;
    sb.push_back('{p, exp, cyc + LAT});
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en      = 1'b1;
    wr_addr_in = a;
    wr_be_in   = be;
    wr_data_in = d;
  endtask

  // One clock edge, then compare every port against the scoreboard.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    for (int p = 0; p < NR; p++) begin
      int idx;
      idx = -1;
      foreach (sb[i]) if (sb[i].port == p && sb[i].due == cyc) idx = i;
      if (idx >= 0) begin
        check($sformatf("rd_valid[%0d]", p), 32'(rd_valid[p]), 32'd1);
        check($sformatf("rd_data[%0d]", p), rd_data_out[p], sb[idx].data);
        last_data[p] = sb[idx].data;
        sb.delete(idx);
      end else begin
        check($sformatf("rd_valid_idle[%0d]", p), 32'(rd_valid[p]), 32'd0);
        check($sformatf("rd_data_hold[%0d]", p), rd_data_out[p], last_data[p]);
      end
    end
  endtask

  task automatic wait_ready(input int n_low);
    for (int i = 0; i < n_low; i++) begin
      tick();
      check("ready_low", 32'(ready), 32'd0);
    end
    tick();
    check("ready_high", 32'(ready), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    for (int p = 0; p < NR; p++) begin
      check($sformatf("rst_data[%0d]", p), rd_data_out[p], 32'd0);
      last_data[p] = '0;
    end
    sb.delete();
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    idle();

    vecs.push_back('{1'b0, 8'h00, 4'h0, 32'h0,        2'b11, 8'h00, 8'hFF, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 8'h10, 4'hF, 32'h11223344, 2'b00, 8'h00, 8'h00, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 8'h10, 4'h5, 32'hAABBCCDD, 2'b01, 8'h10, 8'h00, 32'h11BB33DD, 32'h0});
    vecs.push_back('{1'b0, 8'h00, 4'h0, 32'h0,        2'b11, 8'h10, 8'h10, 32'h11BB33DD, 32'h11BB33DD});
    vecs.push_back('{1'b1, 8'h20, 4'hF, 32'hCAFEF00D, 2'b11, 8'h20, 8'h20, 32'hCAFEF00D, 32'hCAFEF00D});
    vecs.push_back('{1'b0, 8'h00, 4'h0, 32'h0,        2'b11, 8'h20, 8'h20, 32'hCAFEF00D, 32'hCAFEF00D});
    vecs.push_back('{1'b1, 8'h21, 4'hF, 32'h12345678, 2'b11, 8'h20, 8'h21, 32'hCAFEF00D, 32'h12345678});
    vecs.push_back('{1'b1, 8'hFF, 4'hF, 32'h5A5A5A5A, 2'b10, 8'h00, 8'h00, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 8'hFF, 4'h0, 32'hFFFFFFFF, 2'b01, 8'hFF, 8'h00, 32'h5A5A5A5A, 32'h0});
    vecs.push_back('{1'b1, 8'h30, 4'hF, 32'h0000BEEF, 2'b10, 8'h00, 8'h30, 32'h0,        32'h0000BEEF});
    vecs.push_back('{1'b1, 8'h30, 4'h8, 32'h77000000, 2'b01, 8'h30, 8'h00, 32'h7700BEEF, 32'h0});
    vecs.push_back('{1'b0, 8'h00, 4'h0, 32'h0,        2'b11, 8'hFF, 8'h21, 32'h5A5A5A5A, 32'h12345678});
    vecs.push_back('{1'b1, 8'h40, 4'hF, 32'h13579BDF, 2'b10, 8'h00, 8'h40, 32'h0,        32'h13579BDF});
    vecs.push_back('{1'b0, 8'h00, 4'h0, 32'h0,        2'b01, 8'hFF, 8'h00, 32'h5A5A5A5A, 32'h0});

    // Power-on reset and initial clear.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    check("ready_after_release", 32'(ready), 32'd0);
    wait_ready(255);

    foreach (vecs[i]) begin
      idle();
      if (vecs[i].we) drive_write(vecs[i].wa, vecs[i].be, vecs[i].wd);
      if (vecs[i].re[0]) push_read(0, vecs[i].ra0, vecs[i].e0);
      if (vecs[i].re[1]) push_read(1, vecs[i].ra1, vecs[i].e1);
      tick();
    end

    // Outputs must hold after the last read while rd_en stays low.
    idle();
    repeat (5) tick();

    // clr with a simultaneous write: write dropped, read in that cycle completes.
    clr = 1'b1;
    drive_write(8'h30, 4'hF, 32'hDEAD0000);
    push_read(0, 8'h30, 32'h7700BEEF);
    tick();
    check("ready_clr_edge", 32'(ready), 32'd0);
    idle();
    drive_write(8'h05, 4'hF, 32'hFFFFFFFF);
    rd_en         = '1;
    rd_addr_in[0] = 8'h30;
    rd_addr_in[1] = 8'h05;
    wait_ready(255);
    idle();
    push_read(0, 8'h30, 32'h0);
    push_read(1, 8'h05, 32'h0);
    tick();
    idle();
    repeat (LAT) tick();

    // Reset in the middle of a clear restarts it from address 0.
    drive_write(8'h40, 4'hF, 32'h13579BDF);
    push_read(1, 8'h40, 32'h13579BDF);
    tick();
    idle();
    clr = 1'b1;
    push_read(0, 8'h40, 32'h13579BDF);
    tick();
    idle();
    repeat (100) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ready_after_rerelease", 32'(ready), 32'd0);
    wait_ready(255);
    push_read(0, 8'h40, 32'h0);
    push_read(1, 8'hFF, 32'h0);
    tick();
    idle();
    repeat (LAT + 2) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
